scv_test_mailbox: RTL

- Bus-responder end of the uPD7800 external bus: a memory-mapped mailbox into which CPU test programs write progress bytes and completion flags.
- Bytes written by the CPU are queued in a small FIFO and streamed out on a valid/ready port to a bench monitor or debug host.
- Sits beside WRAM/VRAM/cart decode. The CPU is the writer; this block is the reader.

---
 rtl/scv_test_mailbox.sv | 189 ++++++++++++++++++
 1 files changed

// File: rtl/scv_test_mailbox.sv
// scv_test_mailbox: bus-responder mailbox on the uPD7800 external bus.
// The CPU writes progress bytes into a 4-byte register window at BASE. The
// bytes queue in a small FIFO and stream out on a valid/ready port.
//
// Ports:
//   CLK, RESETB        clock, asynchronous active-low reset
//   CP2_NEGEDGE        one-CLK strobe at the CPU write-sample point
//   A[15:0]            CPU address bus
//   DB_I[7:0]          CPU write data
//   DB_O[7:0], DB_OE   registered read data and its valid flag
//   RDB, WRB           CPU read/write strobes, active low
//   OUT_DATA[7:0]      FIFO head byte
//   OUT_VALID          FIFO not empty
//   OUT_READY          consumer accepts the head byte
//   DONE, OVF          sticky test-complete and FIFO-overflow flags
//
// Register map (offset from BASE):
//   +0 DATA   W: push byte, R: last byte written
//   +1 STATUS R: {count[3:0], DONE, OVF, full, empty}
//   +2 CTRL   W: bit0 flush, bit1 set DONE, bit2 clear OVF; R: {6'b0, DONE, 1'b0}
//   +3 reserved
module scv_test_mailbox #(
  parameter logic [15:0] BASE  = 16'h2000,
  parameter int unsigned DEPTH = 8
) (
  input  logic        CLK,
  input  logic        RESETB,
  input  logic        CP2_NEGEDGE,
  input  logic [15:0] A,
  input  logic [7:0]  DB_I,
  output logic [7:0]  DB_O,
  output logic        DB_OE,
  input  logic        RDB,
  input  logic        WRB,
  output logic [7:0]  OUT_DATA,
  output logic        OUT_VALID,
  input  logic        OUT_READY,
  output logic        DONE,
  output logic        OVF
);

  localparam int unsigned PTR_W = $clog2(DEPTH);
  localparam int unsigned CNT_W = PTR_W + 1;
  localparam logic [CNT_W-1:0] FULL_CNT = CNT_W'(DEPTH);

  logic             r_arm;
  logic [PTR_W-1:0] r_rd_ptr;
  logic [PTR_W-1:0] r_wr_ptr;
  logic [CNT_W-1:0] r_count;
  logic [7:0]       r_mem [DEPTH];
  logic [7:0]       r_last;
  logic             r_done;
  logic             r_ovf;
  logic [7:0]       r_db_o;
  logic             r_db_oe;
  logic [7:0]       r_out_data;
  logic             r_out_valid;

  logic             w_hit;
  logic             w_acc;
  logic             w_wr_data;
  logic             w_wr_ctrl;
  logic             w_flush;
  logic             w_empty;
  logic             w_full;
  logic             w_pop;
  logic             w_push_do;
  logic             w_rd_en;
  logic [7:0]       w_rd_mux;
  logic [PTR_W-1:0] w_rd_ptr_nxt;
  logic [PTR_W-1:0] w_wr_ptr_nxt;
  logic [CNT_W-1:0] w_count_nxt;
  logic [7:0]       w_head_nxt;
  logic             w_valid_nxt;

  // Address decode and write qualification; arm limits each CPU write to one accept.
  always_comb begin
    w_hit     = (A[15:2] == BASE[15:2]);
    w_acc     = CP2_NEGEDGE & ~WRB & w_hit & r_arm;
    w_wr_data = w_acc & (A[1:0] == 2'd0);
    w_wr_ctrl = w_acc & (A[1:0] == 2'd2);
    w_flush   = w_wr_ctrl & DB_I[0];
    w_empty   = (r_count == '0);
    w_full    = (r_count == FULL_CNT);
    // Flush overrides any pop in the same cycle.
    w_pop     = ~w_empty & OUT_READY & ~w_flush;
    // A push into a full FIFO still fits when the head leaves the same cycle.
    w_push_do = w_wr_data & (~w_full | w_pop);
    w_rd_en   = w_hit & ~RDB;
  end

  // FIFO pointer/count next state and the head byte presented next cycle.
  always_comb begin
    w_rd_ptr_nxt = r_rd_ptr;
    w_wr_ptr_nxt = r_wr_ptr;
    w_count_nxt  = r_count;
    if (w_flush) begin
      w_rd_ptr_nxt = '0;
      w_wr_ptr_nxt = '0;
      w_count_nxt  = '0;
    end else begin
      if (w_pop) begin
        w_rd_ptr_nxt = r_rd_ptr + PTR_W'(1);
      end
      if (w_push_do) begin
        w_wr_ptr_nxt = r_wr_ptr + PTR_W'(1);
      end
      if (w_push_do && !w_pop) begin
        w_count_nxt = r_count + CNT_W'(1);
      end else if (w_pop && !w_push_do) begin
        w_count_nxt = r_count - CNT_W'(1);
      end
    end
    w_valid_nxt = (w_count_nxt != '0);
    // When the new head is the slot being written this edge, bypass the memory.
    if (w_push_do && (r_wr_ptr == w_rd_ptr_nxt)) begin
      w_head_nxt = DB_I;
    end else begin
      w_head_nxt = r_mem[w_rd_ptr_nxt];
    end
  end

  // Read register select from pre-edge state.
  always_comb begin
    w_rd_mux = 8'h00;
    unique case (A[1:0])
      2'd0:    w_rd_mux = r_last;
      2'd1:    w_rd_mux = {4'(r_count), r_done, r_ovf, w_full, w_empty};
      2'd2:    w_rd_mux = {6'b0, r_done, 1'b0};
      default: w_rd_mux = 8'h00;
    endcase
  end

  // Control and status registers.
  always_ff @(posedge CLK or negedge RESETB) begin
    if (!RESETB) begin
      r_arm       <= 1'b1;
      r_rd_ptr    <= '0;
      r_wr_ptr    <= '0;
      r_count     <= '0;
      r_last      <= 8'h00;
      r_done      <= 1'b0;
      r_ovf       <= 1'b0;
      r_db_o      <= 8'h00;
      r_db_oe     <= 1'b0;
      r_out_data  <= 8'h00;
      r_out_valid <= 1'b0;
    end else begin
      if (WRB) begin
        r_arm <= 1'b1;
      end else if (w_acc) begin
        r_arm <= 1'b0;
      end
      r_rd_ptr    <= w_rd_ptr_nxt;
      r_wr_ptr    <= w_wr_ptr_nxt;
      r_count     <= w_count_nxt;
      r_out_valid <= w_valid_nxt;
      r_out_data  <= w_valid_nxt ? w_head_nxt : 8'h00;
      if (w_wr_data) begin
        r_last <= DB_I;
      end
      if (w_wr_ctrl && DB_I[1]) begin
        r_done <= 1'b1;
      end
      if (w_wr_data && w_full && !w_pop) begin
        r_ovf <= 1'b1;
      end else if (w_wr_ctrl && DB_I[2]) begin
        r_ovf <= 1'b0;
      end
      r_db_oe <= w_rd_en;
      r_db_o  <= w_rd_en ? w_rd_mux : 8'h00;
    end
  end

  // FIFO storage; contents are meaningless until written, so no reset.
  always_ff @(posedge CLK) begin
    if (w_push_do) begin
      r_mem[r_wr_ptr] <= DB_I;
    end
  end

  assign DB_O      = r_db_o;
  assign DB_OE     = r_db_oe;
  assign OUT_DATA  = r_out_data;
  assign OUT_VALID = r_out_valid;
  assign DONE      = r_done;
  assign OVF       = r_ovf;

endmodule
